// File: rtl/button_io_pkg.sv
// Shared definitions for the push-button I/O port: register map and decoder base.
package button_io_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_PENDING = 2'd1,
    REG_MASK    = 2'd2,
    REG_RSVD    = 2'd3
  } reg_addr_e;

  // Word-aligned base of this block in the uC I/O space, used by the port decoder.
  localparam logic [31:0] BUTTON_IO_BASE = 32'h1F80_0010;

endpackage

// File: rtl/debounce_cell.sv
// One button bit: 2-FF synchronizer, stability counter and rising-edge pulse.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic sys_clk,
  input  logic rst_sync,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             stable_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      prev_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      prev_reg <= stable_reg;
      // Any sample agreeing with the accepted level restarts the count.
      if (s2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= s2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign rise   = stable_reg & ~prev_reg;

endmodule

// File: rtl/button_debounce_irq.sv
// Debounced button port with pending/mask registers and a level interrupt.
module button_debounce_irq
  import button_io_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             sys_clk,
  input  logic             rst_sync,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             ce,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic [N_BTN-1:0] btn_stable,
  output logic             irq
);

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending_reg;
  logic [N_BTN-1:0] mask_reg;
  logic             irq_reg;
  logic [N_BTN-1:0] pending_clr;
  logic             wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_cell (
        .sys_clk (sys_clk),
        .rst_sync(rst_sync),
        .raw     (btn_in[gi]),
        .stable  (btn_stable[gi]),
        .rise    (rise[gi])
      );
    end
  endgenerate

  assign wr_en       = ce & wr;
  assign pending_clr = (wr_en && addr == REG_PENDING) ? data_in[N_BTN-1:0] : '0;

  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
    end else begin
      // A new edge in the same cycle as its W1C clear keeps the bit set.
      pending_reg <= (pending_reg & ~pending_clr) | rise;
      if (wr_en && addr == REG_MASK) begin
        mask_reg <= data_in[N_BTN-1:0];
      end
      irq_reg <= |(pending_reg & mask_reg);
    end
  end

  always_comb begin
    data_out = '0;
    if (ce) begin
      case (addr)
        REG_STATUS:  data_out[N_BTN-1:0] = btn_stable;
        REG_PENDING: data_out[N_BTN-1:0] = pending_reg;
        REG_MASK:    data_out[N_BTN-1:0] = mask_reg;
        default:     data_out = '0;
      endcase
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_button_debounce_irq.sv
// Bench for button_debounce_irq: directed scenarios with literal checks plus a
// randomized run compared every cycle against a window-based behavioural model.
module tb_button_debounce_irq;

  localparam int N = 4;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn = '0;
  logic          ce = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic [N-1:0]  btn_stable;
  logic          irq;

  int total = 0;
  int bad   = 0;

  button_debounce_irq #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .sys_clk   (clk),
    .rst_sync  (rst),
    .btn_in    (btn),
    .ce        (ce),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .btn_stable(btn_stable),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A level is accepted once the last D synchronized samples, all taken after
  // the previous acceptance, disagree with the current level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_rose = '0;
  logic [N-1:0] m_pending = '0, m_mask = '0;
  logic         m_irq = 1'b0;
  logic [N-1:0] win[$];
  int           since[N];

  initial begin
    logic [N-1:0] clr;
    bit           all_diff;
    for (int i = 0; i < N; i++) since[i] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_rose = '0;
        m_pending = '0; m_mask = '0; m_irq = 1'b0;
        win.delete();
        for (int i = 0; i < N; i++) since[i] = 0;
      end else begin
        clr = (ce && wr && addr == 2'd1) ? data_in[N-1:0] : '0;
        m_irq = |(m_pending & m_mask);
        m_pending = (m_pending & ~clr) | m_rose;
        if (ce && wr && addr == 2'd2) m_mask = data_in[N-1:0];
        win.push_back(m_s2);
        if (win.size() > D) void'(win.pop_front());
        m_rose = '0;
        for (int i = 0; i < N; i++) begin
          since[i]++;
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
          if (since[i] >= D && all_diff) begin
            m_stable[i] = ~m_stable[i];
            since[i] = 0;
            if (m_stable[i]) m_rose[i] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = btn;
      end
    end
  end

  function automatic logic [31:0] m_dout();
    logic [31:0] r;
    r = '0;
    if (ce) begin
      case (addr)
        2'd0: r[N-1:0] = m_stable;
        2'd1: r[N-1:0] = m_pending;
        2'd2: r[N-1:0] = m_mask;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      total++;
      if (btn_stable !== m_stable || irq !== m_irq || data_out !== m_dout()) begin
        bad++;
        $display("FAIL cycle t=%0t: stable=%b/%b irq=%b/%b dout=%h/%h (actual/required)",
                 $time, btn_stable, m_stable, irq, m_irq, data_out, m_dout());
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    ce = 1'b1; wr = 1'b0; addr = a;
    #1 chk(name, data_out, exp);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    wr = 1'b0; data_in = '0;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    int hold[N];
    // 1. reset and register readback
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rd(2'd0, 32'h0, "reset STATUS");
    rd(2'd1, 32'h0, "reset PENDING");
    rd(2'd2, 32'h0, "reset MASK");
    rd(2'd3, 32'h0, "reset RSVD");
    chk("reset irq", {31'b0, irq}, 32'h0);

    // 2. clean press on bit 3: accepted after exactly 2+D edges
    @(negedge clk);
    btn = 4'b1000; ce = 1'b1; wr = 1'b0; addr = 2'd1;
    repeat (4) post_edge();
    chk("b3 stable edge4", {31'b0, btn_stable[3]}, 32'h0);
    post_edge();
    chk("b3 stable edge5", {31'b0, btn_stable[3]}, 32'h1);
    post_edge();
    chk("b3 PENDING", data_out, 32'h8);
    repeat (2) post_edge();
    chk("b3 irq masked", {31'b0, irq}, 32'h0);
    @(negedge clk) btn = '0;
    repeat (8) @(negedge clk);

    // 3. glitch train on bit 0
    for (int r = 0; r < 4; r++) begin
      btn[0] = 1'b1;
      repeat (2) @(negedge clk);
      btn[0] = 1'b0;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    rd(2'd1, 32'h8, "glitch PENDING");
    chk("glitch stable", {28'b0, btn_stable}, 32'h0);

    // 4. mask, press bit 1, irq one cycle after pending; W1C clear
    wreg(2'd1, 32'hF);
    wreg(2'd2, 32'hF);
    rd(2'd2, 32'hF, "MASK readback");
    @(negedge clk);
    btn = 4'b0010; ce = 1'b1; wr = 1'b0; addr = 2'd1;
    repeat (6) post_edge();
    chk("b1 PENDING", data_out, 32'h2);
    chk("b1 irq lag", {31'b0, irq}, 32'h0);
    post_edge();
    chk("b1 irq", {31'b0, irq}, 32'h1);
    @(negedge clk);
    btn = '0; wr = 1'b1; data_in = 32'h2;
    post_edge();
    chk("W1C PENDING", data_out, 32'h0);
    chk("W1C irq still", {31'b0, irq}, 32'h1);
    @(negedge clk) wr = 1'b0;
    #13 chk("W1C irq drop", {31'b0, irq}, 32'h0);
    repeat (8) @(negedge clk);

    // 5. rising edge on bit 2 collides with W1C of bit 2
    btn = 4'b0100; ce = 1'b1; wr = 1'b0; addr = 2'd1; data_in = '0;
    repeat (5) @(negedge clk);
    wr = 1'b1; data_in = 32'h4;
    post_edge();
    chk("set wins PENDING", data_out, 32'h4);
    @(negedge clk) begin wr = 1'b0; data_in = '0; end
    btn = '0;
    repeat (8) @(negedge clk);

    // 6. held button through a reset pulse mid-count
    btn = 4'b0001; addr = 2'd1; ce = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    post_edge();
    chk("rst stable", {28'b0, btn_stable}, 32'h0);
    chk("rst irq", {31'b0, irq}, 32'h0);
    chk("rst PENDING", data_out, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (4) post_edge();
    chk("post-rst stable edge4", {31'b0, btn_stable[0]}, 32'h0);
    post_edge();
    chk("post-rst stable edge5", {31'b0, btn_stable[0]}, 32'h1);
    post_edge();
    chk("post-rst PENDING", data_out, 32'h1);
    @(negedge clk) btn = '0;
    repeat (8) @(negedge clk);

    // Randomized run
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn[i] = ~btn[i];
          hold[i] = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      ce = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 3) == 0);
      addr = 2'($urandom_range(0, 3));
      data_in = $urandom;
      rst = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
